fifo_rr_arbiter: RTL and testbench

- Upstream neighbour of the SRAM output FIFO.
- Merges N_SRC first-word-fall-through (FWFT) 32-bit source FIFOs into one 32-bit FWFT stream, using a round-robin, burst-limited grant.
- The output connects directly to the SRAM FIFO's FIFO_DATA / FIFO_EMPTY_IN / FIFO_READ_NEXT_OUT.
- A 2-entry registered output buffer decouples source pops from downstream reads, so OUT_DATA holds stable until it is popped.

---
 rtl/fifo_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: merges N_SRC FWFT 32-bit source FIFOs into one FWFT stream.
// Grant is round-robin and burst-limited. A 2-entry registered buffer sits
// between the source pops and the downstream reads, so OUT_DATA stays put
// until it is popped.
// Optional build macro: FIFO_RR_ARBITER_SRC_TAG_EN. When it is defined,
// bits [31:28] of each pushed word are replaced by {1'b0, source index}.
module fifo_rr_arbiter #(
    parameter int N_SRC     = 4,   // 2..8
    parameter int MAX_BURST = 16   // 1..255
) (
    input  logic                 BUS_CLK,
    input  logic                 RST,
    input  logic [32*N_SRC-1:0]  SRC_DATA,
    input  logic [N_SRC-1:0]     SRC_EMPTY,
    output logic [N_SRC-1:0]     SRC_READ,
    input  logic [N_SRC-1:0]     SRC_ENABLE,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_EMPTY,
    input  logic                 OUT_READ,
    output logic [N_SRC-1:0]     GRANT,
    output logic [31:0]          WORD_CNT
);

    localparam int IW = $clog2(N_SRC);

    typedef enum logic {ARB, XFER} state_t;

    state_t          state;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   rr;
    logic [7:0]      burst;
    logic [1:0]      cnt;
    logic [31:0]     buf0;
    logic [31:0]     buf1;
    logic [N_SRC-1:0] grant_q;
    logic [31:0]     word_cnt_q;

    logic [31:0]     src_words [N_SRC];
    logic [31:0]     src_word;
    logic [31:0]     push_word;
    logic            space;
    logic            pop_out;
    logic            src_pop;
    logic            rel;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   next_rr;

    // Unpack the flat source bus so the granted word is a plain array select.
    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_words[i] = SRC_DATA[32*i +: 32];
    end

    assign src_word = src_words[grant_idx];

`ifdef FIFO_RR_ARBITER_SRC_TAG_EN
    // Tag the top nibble with the source index so software can demultiplex.
    assign push_word = {1'b0, 3'(grant_idx), src_word[27:0]};
`else
    assign push_word = src_word;
`endif

    // Buffer has room if not full, or full but the head leaves this cycle.
    assign pop_out = OUT_READ && (cnt != 2'd0);
    assign space   = (cnt < 2'd2) || ((cnt == 2'd2) && OUT_READ);

    // A source pop needs a live grant, room downstream and no reset.
    assign src_pop = (state == XFER) && space && !SRC_EMPTY[grant_idx]
                     && SRC_ENABLE[grant_idx] && !RST;

    // Give the grant back on burst limit, empty source, or disabled source.
    assign rel = (state == XFER) &&
                 ((src_pop && (burst == 8'(MAX_BURST - 1))) ||
                  SRC_EMPTY[grant_idx] || !SRC_ENABLE[grant_idx]);

    assign next_rr = (int'(grant_idx) == N_SRC - 1) ? '0 : grant_idx + 1'b1;

    // Round-robin scan starting at rr: first enabled, non-empty source wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(rr) + k) % N_SRC);
            if (!found && SRC_ENABLE[cand] && !SRC_EMPTY[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // One-hot pop strobe toward the granted source only.
    always_comb begin
        SRC_READ = '0;
        if (src_pop)
            SRC_READ[grant_idx] = 1'b1;
    end

    // Arbitration FSM: ARB picks a source, XFER drains it up to MAX_BURST.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state     <= ARB;
            grant_q   <= '0;
            grant_idx <= '0;
            rr        <= '0;
            burst     <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (found) begin
                        grant_q       <= '0;
                        grant_q[pick] <= 1'b1;
                        grant_idx     <= pick;
                        burst         <= '0;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (src_pop)
                        burst <= burst + 8'd1;
                    if (rel) begin
                        grant_q <= '0;
                        rr      <= next_rr;
                        state   <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Two-entry output buffer; buf0 is always the oldest word.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            cnt  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else if (src_pop && pop_out) begin
            // Count unchanged; the new word lands behind whatever remains.
            if (cnt == 2'd1) begin
                buf0 <= push_word;
            end else begin
                buf0 <= buf1;
                buf1 <= push_word;
            end
        end else if (src_pop) begin
            if (cnt == 2'd0)
                buf0 <= push_word;
            else
                buf1 <= push_word;
            cnt <= cnt + 2'd1;
        end else if (pop_out) begin
            if (cnt == 2'd2)
                buf0 <= buf1;
            cnt <= cnt - 2'd1;
        end
    end

    // Count accepted downstream pops; wraps naturally at 2^32.
    always_ff @(posedge BUS_CLK) begin
        if (RST)
            word_cnt_q <= '0;
        else if (pop_out)
            word_cnt_q <= word_cnt_q + 32'd1;
    end

    assign OUT_DATA  = buf0;
    assign OUT_EMPTY = (cnt == 2'd0);
    assign GRANT     = grant_q;
    assign WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter (N_SRC=4, MAX_BURST=4).
// Sources are modelled as simple FWFT memories popped on SRC_READ.
module tb_fifo_rr_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [32*N-1:0] src_data;
    logic [N-1:0]    src_empty;
    logic [N-1:0]    src_read;
    logic [N-1:0]    src_enable;
    logic [31:0]     out_data;
    logic            out_empty;
    logic            out_read;
    logic [N-1:0]    grant;
    logic [31:0]     word_cnt;

    logic [31:0] mem [N][256];
    int wp [N] = '{default: 0};
    int rp [N] = '{default: 0};
    int rd_cnt [N] = '{default: 0};
    int cyc = 0;
    int multi = 0;
    logic [31:0] obs [$];
    int ord [$];
    int popc [$];

    int checks = 0;
    int errors = 0;

    fifo_rr_arbiter #(.N_SRC(N), .MAX_BURST(MB)) dut (
        .BUS_CLK(clk), .RST(rst), .SRC_DATA(src_data), .SRC_EMPTY(src_empty),
        .SRC_READ(src_read), .SRC_ENABLE(src_enable), .OUT_DATA(out_data),
        .OUT_EMPTY(out_empty), .OUT_READ(out_read), .GRANT(grant),
        .WORD_CNT(word_cnt)
    );

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_src
        assign src_empty[i]        = (rp[i] == wp[i]);
        assign src_data[32*i +: 32] = mem[i][rp[i] % 256];
    end

    // Source pop model and traffic monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_read && !out_empty)
            obs.push_back(out_data);
        for (int i = 0; i < N; i++) begin
            if (src_read[i]) begin
                rp[i]     <= rp[i] + 1;
                rd_cnt[i] <= rd_cnt[i] + 1;
                ord.push_back(i);
                popc.push_back(cyc);
            end
        end
        if ($countones(src_read) > 1)
            multi <= multi + 1;
    end

    function automatic logic [31:0] tg(input int s, input logic [31:0] w);
`ifdef FIFO_RR_ARBITER_SRC_TAG_EN
        return {1'b0, 3'(s), w[27:0]};
`else
        return w;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_src(input int s, input logic [31:0] w);
        mem[s][wp[s] % 256] = w;
        wp[s]++;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        out_read = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        src_enable = '1;
        out_read = 1'b0;
        rst = 1'b1;
        step(3);
        checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL reset_out_empty got=%b exp=1", out_empty); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
        checks++; if (word_cnt !== 32'h0) begin errors++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        checks++; if (src_read !== 4'b0) begin errors++; $display("FAIL reset_src_read got=%b exp=0", src_read); end
        rst = 1'b0;
        // Reads against an empty buffer are ignored.
        out_read = 1'b1;
        step(2);
        checks++; if (word_cnt !== 32'h0 || out_empty !== 1'b1) begin errors++; $display("FAIL empty_read_ignored cnt=%0d empty=%b exp cnt=0 empty=1", word_cnt, out_empty); end
        out_read = 1'b0;
    endtask

    task automatic test_single;
        int b0, r[N];
        bit seen;
        b0 = obs.size();
        for (int i = 0; i < N; i++) r[i] = rd_cnt[i];
        out_read = 1'b1;
        for (int k = 0; k < 3; k++) push_src(1, 32'hA000_0001 + k);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            if (src_read[1]) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL single_first_pop timeout got=0 exp=1"); end
        step(1);
        checks++; if (out_empty !== 1'b0 || out_data !== tg(1, 32'hA000_0001)) begin errors++; $display("FAIL single_latency got=%h empty=%b exp=%h", out_data, out_empty, tg(1, 32'hA000_0001)); end
        step(20);
        checks++; if (obs.size() - b0 != 3) begin errors++; $display("FAIL single_count got=%0d exp=3", obs.size() - b0); end
        else for (int k = 0; k < 3; k++) begin
            checks++; if (obs[b0+k] !== tg(1, 32'hA000_0001 + k)) begin errors++; $display("FAIL single_word%0d got=%h exp=%h", k, obs[b0+k], tg(1, 32'hA000_0001 + k)); end
        end
        checks++; if (word_cnt !== 32'd3) begin errors++; $display("FAIL single_word_cnt got=%0d exp=3", word_cnt); end
        for (int i = 0; i < N; i++) begin
            checks++; if (rd_cnt[i] - r[i] != ((i == 1) ? 3 : 0)) begin errors++; $display("FAIL single_src_read%0d got=%0d exp=%0d", i, rd_cnt[i] - r[i], (i == 1) ? 3 : 0); end
        end
    endtask

    task automatic test_fairness;
        int b0, o0, c0, c2;
        int es [20] = '{0,0,0,0,2,2,2,2,0,0,0,0,2,2,2,2,0,0,2,2};
        logic [31:0] ew;
        do_reset();
        out_read = 1'b1;
        b0 = obs.size();
        o0 = ord.size();
        for (int k = 0; k < 10; k++) begin
            push_src(0, 32'hB000_0000 + k);
            push_src(2, 32'hC000_0000 + k);
        end
        step(60);
        checks++; if (ord.size() - o0 != 20 || obs.size() - b0 != 20) begin errors++; $display("FAIL fair_count pops=%0d words=%0d exp=20", ord.size() - o0, obs.size() - b0); end
        else begin
            c0 = 0; c2 = 0;
            for (int j = 0; j < 20; j++) begin
                checks++; if (ord[o0+j] != es[j]) begin errors++; $display("FAIL fair_order%0d got=%0d exp=%0d", j, ord[o0+j], es[j]); end
                if (es[j] == 0) begin ew = tg(0, 32'hB000_0000 + c0); c0++; end
                else begin ew = tg(2, 32'hC000_0000 + c2); c2++; end
                checks++; if (obs[b0+j] !== ew) begin errors++; $display("FAIL fair_word%0d got=%h exp=%h", j, obs[b0+j], ew); end
            end
            // One bubble per burst-limit handover; an empty-source release adds one more.
            for (int j = 1; j < 20; j++) begin
                int eg;
                eg = (j == 4 || j == 8 || j == 12 || j == 16) ? 2 : (j == 18) ? 3 : 1;
                checks++; if (popc[o0+j] - popc[o0+j-1] != eg) begin errors++; $display("FAIL fair_gap%0d got=%0d exp=%0d", j, popc[o0+j] - popc[o0+j-1], eg); end
            end
        end
        checks++; if (word_cnt !== 32'd20) begin errors++; $display("FAIL fair_word_cnt got=%0d exp=20", word_cnt); end
    endtask

    task automatic test_backpressure;
        int b0, r3;
        do_reset();
        out_read = 1'b0;
        b0 = obs.size();
        r3 = rd_cnt[3];
        for (int k = 0; k < 5; k++) push_src(3, 32'hD000_0000 + k);
        step(5);
        checks++; if (rd_cnt[3] - r3 != 2) begin errors++; $display("FAIL bp_pops_early got=%0d exp=2", rd_cnt[3] - r3); end
        checks++; if (out_empty !== 1'b0 || out_data !== tg(3, 32'hD000_0000)) begin errors++; $display("FAIL bp_head_early got=%h empty=%b exp=%h", out_data, out_empty, tg(3, 32'hD000_0000)); end
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL bp_grant got=%b exp=1000", grant); end
        step(15);
        checks++; if (rd_cnt[3] - r3 != 2) begin errors++; $display("FAIL bp_pops_held got=%0d exp=2", rd_cnt[3] - r3); end
        checks++; if (out_data !== tg(3, 32'hD000_0000)) begin errors++; $display("FAIL bp_head_stable got=%h exp=%h", out_data, tg(3, 32'hD000_0000)); end
        out_read = 1'b1;
        step(20);
        checks++; if (obs.size() - b0 != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", obs.size() - b0); end
        else for (int k = 0; k < 5; k++) begin
            checks++; if (obs[b0+k] !== tg(3, 32'hD000_0000 + k)) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", k, obs[b0+k], tg(3, 32'hD000_0000 + k)); end
        end
        checks++; if (rd_cnt[3] - r3 != 5 || word_cnt !== 32'd5) begin errors++; $display("FAIL bp_totals pops=%0d cnt=%0d exp=5", rd_cnt[3] - r3, word_cnt); end
    endtask

    task automatic test_disable;
        int b0, r0, r1;
        bit hit;
        logic [31:0] ew [4];
        do_reset();
        out_read = 1'b1;
        b0 = obs.size();
        r0 = rd_cnt[0];
        r1 = rd_cnt[1];
        for (int k = 0; k < 8; k++) push_src(0, 32'hE000_0000 + k);
        for (int k = 0; k < 2; k++) push_src(1, 32'hF000_0000 + k);
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step(1);
            if (rd_cnt[0] - r0 == 2) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL dis_two_pops timeout got=%0d exp=2", rd_cnt[0] - r0); end
        src_enable[0] = 1'b0;
        step(1);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL dis_grant_drop got=%b exp=0000", grant); end
        step(1);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL dis_next_grant got=%b exp=0010", grant); end
        step(20);
        checks++; if (rd_cnt[0] - r0 != 2 || rd_cnt[1] - r1 != 2) begin errors++; $display("FAIL dis_pops got=%0d/%0d exp=2/2", rd_cnt[0] - r0, rd_cnt[1] - r1); end
        checks++; if (wp[0] - rp[0] != 6) begin errors++; $display("FAIL dis_left got=%0d exp=6", wp[0] - rp[0]); end
        ew = '{tg(0, 32'hE000_0000), tg(0, 32'hE000_0001), tg(1, 32'hF000_0000), tg(1, 32'hF000_0001)};
        checks++; if (obs.size() - b0 != 4) begin errors++; $display("FAIL dis_count got=%0d exp=4", obs.size() - b0); end
        else for (int k = 0; k < 4; k++) begin
            checks++; if (obs[b0+k] !== ew[k]) begin errors++; $display("FAIL dis_word%0d got=%h exp=%h", k, obs[b0+k], ew[k]); end
        end
    endtask

    task automatic test_reset_mid;
        int b0, o0, r0;
        bit hit;
        logic [31:0] ew [5];
        int eo [5] = '{0,0,0,0,2};
        do_reset();
        src_enable[0] = 1'b1;
        out_read = 1'b0;
        r0 = rd_cnt[0];
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(1);
            if (rd_cnt[0] - r0 == 2) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstm_fill timeout got=%0d exp=2", rd_cnt[0] - r0); end
        step(3);
        checks++; if (rd_cnt[0] - r0 != 2 || out_empty !== 1'b0) begin errors++; $display("FAIL rstm_full pops=%0d empty=%b exp=2/0", rd_cnt[0] - r0, out_empty); end
        push_src(2, 32'h0000_0055);
        rst = 1'b1;
        out_read = 1'b1;
        #1;
        checks++; if (src_read !== 4'b0) begin errors++; $display("FAIL rstm_no_read got=%b exp=0000", src_read); end
        step(1);
        checks++; if (out_empty !== 1'b1 || grant !== 4'b0 || word_cnt !== 32'h0) begin errors++; $display("FAIL rstm_state empty=%b grant=%b cnt=%0d exp=1/0000/0", out_empty, grant, word_cnt); end
        checks++; if (src_read !== 4'b0) begin errors++; $display("FAIL rstm_no_read2 got=%b exp=0000", src_read); end
        b0 = obs.size();
        o0 = ord.size();
        rst = 1'b0;
        step(30);
        ew = '{tg(0, 32'hE000_0004), tg(0, 32'hE000_0005), tg(0, 32'hE000_0006), tg(0, 32'hE000_0007), tg(2, 32'h0000_0055)};
        checks++; if (obs.size() - b0 != 5 || ord.size() - o0 != 5) begin errors++; $display("FAIL rstm_count words=%0d pops=%0d exp=5", obs.size() - b0, ord.size() - o0); end
        else for (int k = 0; k < 5; k++) begin
            checks++; if (obs[b0+k] !== ew[k] || ord[o0+k] != eo[k]) begin errors++; $display("FAIL rstm_word%0d got=%h src=%0d exp=%h src=%0d", k, obs[b0+k], ord[o0+k], ew[k], eo[k]); end
        end
        checks++; if (word_cnt !== 32'd5) begin errors++; $display("FAIL rstm_word_cnt got=%0d exp=5", word_cnt); end
    endtask

    task automatic test_tag;
        logic [31:0] exp_w;
        bit hit;
`ifdef FIFO_RR_ARBITER_SRC_TAG_EN
        exp_w = 32'h2FFF_FFFF;
`else
        exp_w = 32'hFFFF_FFFF;
`endif
        do_reset();
        out_read = 1'b0;
        push_src(2, 32'hFFFF_FFFF);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step(1);
            if (!out_empty) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL tag_arrive timeout got=empty exp=word"); end
        checks++; if (out_data !== exp_w) begin errors++; $display("FAIL tag_word got=%h exp=%h", out_data, exp_w); end
        out_read = 1'b1;
        step(5);
        checks++; if (out_empty !== 1'b1 || word_cnt !== 32'd1) begin errors++; $display("FAIL tag_drain empty=%b cnt=%0d exp=1/1", out_empty, word_cnt); end
    endtask

    initial begin
        src_enable = '1;
        out_read = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_disable();
        test_reset_mid();
        test_tag();
        checks++; if (multi != 0) begin errors++; $display("FAIL src_read_onehot got=%0d exp=0", multi); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
